// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states, op select and HI/LO source.
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DZERO  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_RUN    = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_TOUT   = 3'd6
    } state_t;

    localparam logic OP_MULT       = 1'b0;
    localparam logic OP_DIV        = 1'b1;
    localparam logic HILO_SRC_MULT = 1'b0;
    localparam logic HILO_SRC_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_timeout_cnt.sv
// Clearable, enabled RUN-cycle counter; tc flags the last permitted RUN cycle (count == TIMEOUT-1).
module muldiv_timeout_cnt #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the iterative multiplier/divider: zero check, unit start, bounded wait, HI/LO commit, done.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] rt_val,
    input  logic        unit_done,
    output logic        mult_start,
    output logic        div_start,
    output logic        hi_write,
    output logic        lo_write,
    output logic        hilo_src,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc,
    output logic        timeout_err
);

    state_t state_q;
    state_t state_d;
    logic   op_q;
    logic   op_d;
    logic   cnt_clr;
    logic   cnt_en;
    logic   cnt_tc;

    muldiv_timeout_cnt #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) u_timeout_cnt (
        .clk  (clk),
        .reset(reset),
        .clr_i(cnt_clr),
        .en_i (cnt_en),
        .tc_o (cnt_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Outputs depend only on state_q/op_q; inputs steer just the next state and counter.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        mult_start   = 1'b0;
        div_start    = 1'b0;
        hi_write     = 1'b0;
        lo_write     = 1'b0;
        hilo_src     = HILO_SRC_MULT;
        busy         = (state_q != ST_IDLE);
        done         = 1'b0;
        div_zero_exc = 1'b0;
        timeout_err  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = op;
                    if (op == OP_DIV && rt_val == 32'd0) begin
                        state_d = ST_DZERO;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_DZERO: begin
                div_zero_exc = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_LAUNCH: begin
                mult_start = (op_q == OP_MULT);
                div_start  = (op_q == OP_DIV);
                cnt_clr    = 1'b1;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                // unit_done takes priority over an expiring timeout in the same cycle
                if (unit_done) begin
                    state_d = ST_WRITE;
                end else if (cnt_tc) begin
                    state_d = ST_TOUT;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_WRITE: begin
                hi_write = 1'b1;
                lo_write = 1'b1;
                hilo_src = (op_q == OP_DIV) ? HILO_SRC_DIV : HILO_SRC_MULT;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_TOUT: begin
                timeout_err = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: per-cycle pulse counters plus point checks of the outputs.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] rt_val = 32'd0;
    logic        unit_done = 1'b0;
    logic        mult_start, div_start, hi_write, lo_write, hilo_src;
    logic        busy, done, div_zero_exc, timeout_err;

    int total = 0;
    int bad = 0;
    int n_mult, n_div, n_hw, n_lw, n_done, n_dz, n_to, n_busy, n_src_div;

    muldiv_sequencer #(.TIMEOUT(64), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rt_val      (rt_val),
        .unit_done   (unit_done),
        .mult_start  (mult_start),
        .div_start   (div_start),
        .hi_write    (hi_write),
        .lo_write    (lo_write),
        .hilo_src    (hilo_src),
        .busy        (busy),
        .done        (done),
        .div_zero_exc(div_zero_exc),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_mult    += int'(mult_start);
        n_div     += int'(div_start);
        n_hw      += int'(hi_write);
        n_lw      += int'(lo_write);
        n_done    += int'(done);
        n_dz      += int'(div_zero_exc);
        n_to      += int'(timeout_err);
        n_busy    += int'(busy);
        n_src_div += int'(hi_write & hilo_src);
    end

    function automatic logic [8:0] outs();
        return {mult_start, div_start, hi_write, lo_write, hilo_src,
                busy, done, div_zero_exc, timeout_err};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        n_mult = 0; n_div = 0; n_hw = 0; n_lw = 0; n_done = 0;
        n_dz = 0; n_to = 0; n_busy = 0; n_src_div = 0;
    endtask

    initial begin
        clr_counts();
        // Reset state
        #2;
        chk("reset_outs", int'(outs()), 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("idle_outs", int'(outs()), 0);

        // MULT, unit_done on the 32nd RUN cycle
        clr_counts();
        start = 1'b1; op = 1'b0; rt_val = 32'd5;
        tick();
        chk("mul_launch_mstart", int'(mult_start), 1);
        chk("mul_launch_dstart", int'(div_start), 0);
        start = 1'b0;
        tick();
        repeat (31) tick();
        unit_done = 1'b1;
        tick();
        chk("mul_write_hw", int'(hi_write), 1);
        chk("mul_write_lw", int'(lo_write), 1);
        chk("mul_write_src", int'(hilo_src), 0);
        chk("mul_write_nodone", int'(done), 0);
        unit_done = 1'b0;
        tick();
        chk("mul_done", int'(done), 1);
        tick();
        chk("mul_idle_busy", int'(busy), 0);
        chk("mul_n_mult", n_mult, 1);
        chk("mul_n_div", n_div, 0);
        chk("mul_n_hw", n_hw, 1);
        chk("mul_n_done", n_done, 1);
        chk("mul_n_busy", n_busy, 35);

        // DIV by zero
        clr_counts();
        start = 1'b1; op = 1'b1; rt_val = 32'd0;
        tick();
        chk("dz_exc", int'(div_zero_exc), 1);
        chk("dz_busy", int'(busy), 1);
        start = 1'b0;
        tick();
        chk("dz_idle_outs", int'(outs()), 0);
        repeat (3) tick();
        chk("dz_n_dz", n_dz, 1);
        chk("dz_n_busy", n_busy, 1);
        chk("dz_n_div", n_div, 0);
        chk("dz_n_hw", n_hw + n_lw, 0);
        chk("dz_n_done", n_done, 0);

        // DIV that never finishes
        clr_counts();
        start = 1'b1; op = 1'b1; rt_val = 32'd7;
        tick();
        chk("to_launch_dstart", int'(div_start), 1);
        chk("to_launch_mstart", int'(mult_start), 0);
        start = 1'b0;
        tick();
        repeat (63) tick();
        chk("to_run64_noerr", int'(timeout_err), 0);
        tick();
        chk("to_err", int'(timeout_err), 1);
        tick();
        chk("to_idle_busy", int'(busy), 0);
        chk("to_n_to", n_to, 1);
        chk("to_n_hw", n_hw + n_lw, 0);
        chk("to_n_done", n_done, 0);
        chk("to_n_busy", n_busy, 66);

        // unit_done on the terminal-count RUN cycle
        clr_counts();
        start = 1'b1; op = 1'b1; rt_val = 32'd3;
        tick();
        start = 1'b0;
        tick();
        repeat (63) tick();
        unit_done = 1'b1;
        tick();
        chk("tc_write_hw", int'(hi_write), 1);
        chk("tc_write_src", int'(hilo_src), 1);
        chk("tc_write_noerr", int'(timeout_err), 0);
        unit_done = 1'b0;
        tick();
        chk("tc_done", int'(done), 1);
        tick();
        chk("tc_n_to", n_to, 0);
        chk("tc_n_done", n_done, 1);

        // start during RUN is ignored
        clr_counts();
        start = 1'b1; op = 1'b0; rt_val = 32'd9;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; op = 1'b1; rt_val = 32'd0;
        tick(); tick();
        start = 1'b0;
        repeat (5) tick();
        unit_done = 1'b1;
        tick();
        unit_done = 1'b0;
        tick(); tick();
        repeat (3) tick();
        chk("ign_n_mult", n_mult, 1);
        chk("ign_n_div", n_div, 0);
        chk("ign_n_dz", n_dz, 0);
        chk("ign_n_done", n_done, 1);
        chk("ign_n_src_div", n_src_div, 0);

        // Reset in RUN
        clr_counts();
        start = 1'b1; op = 1'b0; rt_val = 32'd4;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("rst_run_outs", int'(outs()), 0);
        unit_done = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        unit_done = 1'b0;
        repeat (3) tick();
        chk("rst_run_n_hw", n_hw, 0);
        chk("rst_run_n_done", n_done, 0);

        // Reset in WRITE
        clr_counts();
        start = 1'b1; op = 1'b1; rt_val = 32'd9;
        tick();
        start = 1'b0;
        tick();
        unit_done = 1'b1;
        tick();
        chk("rst_wr_hw_pre", int'(hi_write), 1);
        chk("rst_wr_src_pre", int'(hilo_src), 1);
        reset = 1'b1;
        unit_done = 1'b0;
        #1;
        chk("rst_wr_outs", int'(outs()), 0);
        #2;
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_wr_n_hw", n_hw, 0);
        chk("rst_wr_n_done", n_done, 0);

        // Full minimum-latency MULT after reset release
        clr_counts();
        start = 1'b1; op = 1'b0; rt_val = 32'd3;
        tick();
        chk("post_mstart", int'(mult_start), 1);
        start = 1'b0;
        unit_done = 1'b1;
        tick();
        chk("post_run_busy", int'(busy), 1);
        tick();
        chk("post_write_hw", int'(hi_write), 1);
        chk("post_write_src", int'(hilo_src), 0);
        unit_done = 1'b0;
        tick();
        chk("post_done_e4", int'(done), 1);
        tick();
        chk("post_idle_outs", int'(outs()), 0);
        chk("post_n_done", n_done, 1);
        chk("post_n_busy", n_busy, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
